// File: rtl/membus_arbiter.sv
// Two-master arbiter for a single-port data memory: CPU (m0) and DMA (m1).
// Issues one command per grant cycle and routes each read return to its issuer.
module membus_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int RD_LATENCY   = 1,
   parameter int PRIO_MODE    = 0,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int RC_W = $clog2(RD_LATENCY + 1);
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [RC_W-1:0] RD_LAST    = RC_W'(RD_LATENCY - 1);
   localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

   typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [RC_W-1:0]   rd_cnt_q, rd_cnt_d;
   logic [SC_W-1:0]   starve_q, starve_d;
   logic              rd_owner_q, rd_owner_d;
   logic              ret_pend_q, ret_pend_d;
   logic              last_gnt_q, last_gnt_d;
   logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

   logic              win_m0, win_m1, issue;
   logic              cmd_we;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              ret_m0, ret_m1;

   always_comb begin
      win_m0     = 1'b0;
      win_m1     = 1'b0;
      state_d    = state_q;
      rd_cnt_d   = rd_cnt_q;
      rd_owner_d = rd_owner_q;
      ret_pend_d = 1'b0;
      last_gnt_d = last_gnt_q;
      starve_d   = starve_q;

      // Grants are only possible in IDLE, which includes the cycle a read returns.
      if (state_q == IDLE) begin
         if (m0_req && m1_req) begin
            if (PRIO_MODE == 0) begin
               win_m0 = last_gnt_q;
               win_m1 = ~last_gnt_q;
            end else begin
               win_m1 = (starve_q == STARVE_MAX);
               win_m0 = ~win_m1;
            end
         end else begin
            win_m0 = m0_req;
            win_m1 = m1_req;
         end
      end

      issue     = win_m0 | win_m1;
      cmd_we    = win_m1 ? m1_we    : m0_we;
      cmd_addr  = win_m1 ? m1_addr  : m0_addr;
      cmd_wdata = win_m1 ? m1_wdata : m0_wdata;

      case (state_q)
         IDLE: begin
            if (issue && !cmd_we) begin
               rd_owner_d = win_m1;
               if (RD_LATENCY == 1) begin
                  ret_pend_d = 1'b1;
               end else begin
                  state_d  = RD_WAIT;
                  rd_cnt_d = RC_W'(1);
               end
            end
         end
         RD_WAIT: begin
            if (rd_cnt_q == RD_LAST) begin
               state_d    = IDLE;
               rd_cnt_d   = '0;
               ret_pend_d = 1'b1;
            end else begin
               rd_cnt_d = rd_cnt_q + RC_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (issue) last_gnt_d = win_m1;

      // Starvation counter runs every cycle m1 is left waiting, including RD_WAIT.
      if (m1_req && !win_m1) begin
         starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SC_W'(1);
      end else begin
         starve_d = '0;
      end
   end

   assign ret_m0 = ret_pend_q & ~rd_owner_q;
   assign ret_m1 = ret_pend_q &  rd_owner_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         rd_cnt_q   <= '0;
         starve_q   <= '0;
         rd_owner_q <= 1'b0;
         ret_pend_q <= 1'b0;
         last_gnt_q <= 1'b1;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         rd_cnt_q   <= rd_cnt_d;
         starve_q   <= starve_d;
         rd_owner_q <= rd_owner_d;
         ret_pend_q <= ret_pend_d;
         last_gnt_q <= last_gnt_d;
         if (ret_m0) m0_rdata_q <= mem_rdata;
         if (ret_m1) m1_rdata_q <= mem_rdata;
      end
   end

   // Combinational outputs are gated so everything reads 0 the moment reset asserts.
   assign m0_gnt    = reset & win_m0;
   assign m1_gnt    = reset & win_m1;
   assign mem_rd    = reset & issue & ~cmd_we;
   assign mem_wr    = reset & issue & cmd_we;
   assign mem_addr  = (reset && issue) ? cmd_addr  : '0;
   assign mem_wdata = (reset && issue) ? cmd_wdata : '0;
   assign m0_rvalid = reset & ret_m0;
   assign m1_rvalid = reset & ret_m1;
   assign m0_rdata  = m0_rvalid ? mem_rdata : m0_rdata_q;
   assign m1_rdata  = m1_rvalid ? mem_rdata : m1_rdata_q;

endmodule

// File: tb/tb_membus_arbiter.sv
// Bench for membus_arbiter: three configurations driven side by side and compared
// each cycle against a cycle-counting reference model of the grant/return rules.
module tb_membus_arbiter;

   localparam int NI = 3;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [NI-1:0]       m0_req, m0_we, m0_gnt, m0_rvalid;
   logic [NI-1:0]       m1_req, m1_we, m1_gnt, m1_rvalid;
   logic [NI-1:0]       mem_rd, mem_wr;
   logic [NI-1:0][31:0] m0_addr, m0_wdata, m0_rdata;
   logic [NI-1:0][31:0] m1_addr, m1_wdata, m1_rdata;
   logic [NI-1:0][31:0] mem_addr, mem_wdata, mem_rdata;

   // u0: latency 1 round-robin, u1: latency 3 round-robin, u2: latency 2 fixed priority
   for (genvar g = 0; g < NI; g++) begin : g_dut
      membus_arbiter #(
         .ADDR_W(32), .DATA_W(32),
         .RD_LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 2)),
         .PRIO_MODE((g == 2) ? 1 : 0),
         .STARVE_LIMIT((g == 2) ? 4 : 8)
      ) u_dut (
         .clk(clk), .reset(reset),
         .m0_req(m0_req[g]), .m0_we(m0_we[g]), .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]),
         .m0_gnt(m0_gnt[g]), .m0_rvalid(m0_rvalid[g]), .m0_rdata(m0_rdata[g]),
         .m1_req(m1_req[g]), .m1_we(m1_we[g]), .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]),
         .m1_gnt(m1_gnt[g]), .m1_rvalid(m1_rvalid[g]), .m1_rdata(m1_rdata[g]),
         .mem_rd(mem_rd[g]), .mem_wr(mem_wr[g]), .mem_addr(mem_addr[g]),
         .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
      );
   end

   function automatic int lat_of(int i);
      return (i == 0) ? 1 : ((i == 1) ? 3 : 2);
   endfunction
   function automatic bit prio_of(int i);
      return (i == 2);
   endfunction
   function automatic int limit_of(int i);
      return (i == 2) ? 4 : 8;
   endfunction

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Requester-side command slots and directed templates
   bit          rnd_mode;
   bit          c_req [NI][2], c_we [NI][2], g_prev [NI][2];
   logic [31:0] c_addr [NI][2], c_wdata [NI][2];
   bit          want_req [NI][2], want_we [NI][2];
   logic [31:0] want_addr [NI][2], want_wdata [NI][2];

   // Reference model: cycle numbers instead of states
   int          cyc;
   int          free_at [NI];
   bit          ret_vld [NI];
   int          ret_cyc [NI], ret_own [NI];
   int          last [NI], wait_c [NI];
   logic [31:0] hold0 [NI], hold1 [NI];

   // Per-cycle snapshots and counters of what the DUT did
   bit s_g0 [NI], s_g1 [NI], s_rv0 [NI], s_rv1 [NI];
   int cnt_g0 [NI], cnt_g1 [NI], cnt_rv0 [NI], cnt_rv1 [NI];

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         free_at[i] = 0;
         ret_vld[i] = 1'b0;
         last[i]    = 1;
         wait_c[i]  = 0;
         hold0[i]   = '0;
         hold1[i]   = '0;
         g_prev[i][0] = 1'b0;
         g_prev[i][1] = 1'b0;
      end
   endtask

   task automatic clr_cnt();
      for (int i = 0; i < NI; i++) begin
         cnt_g0[i] = 0; cnt_g1[i] = 0; cnt_rv0[i] = 0; cnt_rv1[i] = 0;
      end
   endtask

   task automatic set_want(input int i, input int m, input bit req, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata);
      want_req[i][m] = req; want_we[i][m] = we;
      want_addr[i][m] = addr; want_wdata[i][m] = wdata;
   endtask

   task automatic clear_want();
      for (int i = 0; i < NI; i++)
         for (int m = 0; m < 2; m++) set_want(i, m, 1'b0, 1'b0, '0, '0);
   endtask

   // A slot only takes a new command once the previous one was granted.
   task automatic drive_cycle();
      for (int i = 0; i < NI; i++) begin
         for (int m = 0; m < 2; m++) begin
            if (!c_req[i][m] || g_prev[i][m]) begin
               if (rnd_mode) begin
                  c_req[i][m]   = ($urandom_range(0, 99) < 55);
                  c_we[i][m]    = 1'($urandom_range(0, 1));
                  c_addr[i][m]  = $urandom & 32'hFFFF_FFFC;
                  c_wdata[i][m] = $urandom;
               end else begin
                  c_req[i][m]   = want_req[i][m];
                  c_we[i][m]    = want_we[i][m];
                  c_addr[i][m]  = want_addr[i][m];
                  c_wdata[i][m] = want_wdata[i][m];
               end
            end
            g_prev[i][m] = 1'b0;
         end
         m0_req[i] = c_req[i][0]; m0_we[i] = c_we[i][0];
         m0_addr[i] = c_addr[i][0]; m0_wdata[i] = c_wdata[i][0];
         m1_req[i] = c_req[i][1]; m1_we[i] = c_we[i][1];
         m1_addr[i] = c_addr[i][1]; m1_wdata[i] = c_wdata[i][1];
         mem_rdata[i] = $urandom;
      end
   endtask

   task automatic model_check_commit();
      for (int i = 0; i < NI; i++) begin
         int w, lat;
         bit rv, e_rv0, e_rv1, e_rd, e_wr;
         logic [31:0] e0, e1;
         lat = lat_of(i);
         w   = -1;
         if (cyc >= free_at[i]) begin
            if (c_req[i][0] && c_req[i][1]) begin
               if (prio_of(i)) w = (wait_c[i] == limit_of(i)) ? 1 : 0;
               else            w = 1 - last[i];
            end else if (c_req[i][0]) w = 0;
            else if (c_req[i][1])     w = 1;
         end
         rv    = ret_vld[i] && (ret_cyc[i] == cyc);
         e_rv0 = rv && (ret_own[i] == 0);
         e_rv1 = rv && (ret_own[i] == 1);
         e0    = e_rv0 ? mem_rdata[i] : hold0[i];
         e1    = e_rv1 ? mem_rdata[i] : hold1[i];
         e_rd  = (w >= 0) && !c_we[i][(w < 0) ? 0 : w];
         e_wr  = (w >= 0) &&  c_we[i][(w < 0) ? 0 : w];

         check($sformatf("u%0d_m0_gnt@%0d", i, cyc), 32'(m0_gnt[i]), 32'(w == 0));
         check($sformatf("u%0d_m1_gnt@%0d", i, cyc), 32'(m1_gnt[i]), 32'(w == 1));
         check($sformatf("u%0d_mem_rd@%0d", i, cyc), 32'(mem_rd[i]), 32'(e_rd));
         check($sformatf("u%0d_mem_wr@%0d", i, cyc), 32'(mem_wr[i]), 32'(e_wr));
         if (w >= 0) begin
            check($sformatf("u%0d_mem_addr@%0d", i, cyc), mem_addr[i], c_addr[i][w]);
            check($sformatf("u%0d_mem_wdata@%0d", i, cyc), mem_wdata[i], c_wdata[i][w]);
         end
         check($sformatf("u%0d_m0_rvalid@%0d", i, cyc), 32'(m0_rvalid[i]), 32'(e_rv0));
         check($sformatf("u%0d_m1_rvalid@%0d", i, cyc), 32'(m1_rvalid[i]), 32'(e_rv1));
         check($sformatf("u%0d_m0_rdata@%0d", i, cyc), m0_rdata[i], e0);
         check($sformatf("u%0d_m1_rdata@%0d", i, cyc), m1_rdata[i], e1);

         s_g0[i] = m0_gnt[i]; s_g1[i] = m1_gnt[i];
         s_rv0[i] = m0_rvalid[i]; s_rv1[i] = m1_rvalid[i];
         cnt_g0[i] += int'(m0_gnt[i]); cnt_g1[i] += int'(m1_gnt[i]);
         cnt_rv0[i] += int'(m0_rvalid[i]); cnt_rv1[i] += int'(m1_rvalid[i]);

         if (rv) begin
            if (ret_own[i] == 0) hold0[i] = mem_rdata[i];
            else                 hold1[i] = mem_rdata[i];
            ret_vld[i] = 1'b0;
         end
         if (w >= 0) begin
            last[i] = w;
            g_prev[i][w] = 1'b1;
            if (!c_we[i][w]) begin
               ret_vld[i] = 1'b1;
               ret_cyc[i] = cyc + lat;
               ret_own[i] = w;
               free_at[i] = cyc + lat;
            end else begin
               free_at[i] = cyc + 1;
            end
         end
         if (c_req[i][1] && w != 1) wait_c[i] = (wait_c[i] < limit_of(i)) ? wait_c[i] + 1 : limit_of(i);
         else                       wait_c[i] = 0;
      end
      cyc++;
   endtask

   task automatic step();
      @(posedge clk);
      #1 drive_cycle();
      #2 model_check_commit();
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("%s_u%0d_ctl", tag, i),
               32'({m0_gnt[i], m1_gnt[i], m0_rvalid[i], m1_rvalid[i], mem_rd[i], mem_wr[i]}), 32'd0);
         check($sformatf("%s_u%0d_m0_rdata", tag, i), m0_rdata[i], 32'd0);
         check($sformatf("%s_u%0d_m1_rdata", tag, i), m1_rdata[i], 32'd0);
         check($sformatf("%s_u%0d_mem_addr", tag, i), mem_addr[i], 32'd0);
         check($sformatf("%s_u%0d_mem_wdata", tag, i), mem_wdata[i], 32'd0);
      end
   endtask

   // Reset asserted mid-cycle, held across one edge, released just after the next edge.
   task automatic apply_reset();
      @(posedge clk);
      #1 drive_cycle();
      #1 reset = 1'b0;
      #1 check_all_zero("rst_async");
      @(posedge clk);
      #1 check_all_zero("rst_held");
      reset = 1'b1;
      model_reset();
      drive_cycle();
      #2 model_check_commit();
   endtask

   task automatic drain();
      clear_want();
      repeat (8) step();
   endtask

   initial begin
      rnd_mode = 1'b0;
      cyc = 0;
      m0_req = '0; m0_we = '0; m0_addr = '0; m0_wdata = '0;
      m1_req = '0; m1_we = '0; m1_addr = '0; m1_wdata = '0;
      mem_rdata = '0;
      for (int i = 0; i < NI; i++)
         for (int m = 0; m < 2; m++) begin
            c_req[i][m] = 1'b0; c_we[i][m] = 1'b0; c_addr[i][m] = '0; c_wdata[i][m] = '0;
         end
      clear_want();
      model_reset();
      clr_cnt();
      apply_reset();
      drain();

      // Reset in the cycle after a latency-3 read issues; tie afterwards goes to m0
      set_want(1, 0, 1'b1, 1'b0, 32'h40, 32'h0);
      step();
      check("t1_read_gnt", 32'(s_g0[1]), 32'd1);
      for (int i = 0; i < NI; i++) begin
         set_want(i, 0, 1'b1, 1'b1, 32'h100 + 32'(i), 32'hA0 + 32'(i));
         set_want(i, 1, 1'b1, 1'b1, 32'h200 + 32'(i), 32'hB0 + 32'(i));
      end
      apply_reset();
      check("t1_tie_m0", 32'(s_g0[1]), 32'd1);
      check("t1_tie_not_m1", 32'(s_g1[1]), 32'd0);
      clr_cnt();
      repeat (4) step();
      check("t1_no_stale_rvalid", 32'(cnt_rv0[1]), 32'd0);
      drain();

      // Back-to-back writes from m0 alone
      clr_cnt();
      set_want(0, 0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
      repeat (4) step();
      check("t2_m0_gnt_cnt", 32'(cnt_g0[0]), 32'd4);
      check("t2_m1_gnt_cnt", 32'(cnt_g1[0]), 32'd0);
      drain();

      // Round-robin reads at latency 1
      clr_cnt();
      set_want(0, 0, 1'b1, 1'b0, 32'h100, 32'h0);
      set_want(0, 1, 1'b1, 1'b0, 32'h200, 32'h0);
      repeat (8) step();
      check("t3_m0_gnt_cnt", 32'(cnt_g0[0]), 32'd4);
      check("t3_m1_gnt_cnt", 32'(cnt_g1[0]), 32'd4);
      check("t3_rvalid_cnt", 32'(cnt_rv0[0] + cnt_rv1[0]), 32'd7);
      drain();

      // Latency-3 read blocks m1 for two cycles, then grant coincides with return
      set_want(1, 0, 1'b1, 1'b0, 32'h20, 32'h0);
      step();
      check("t4_m0_gnt", 32'(s_g0[1]), 32'd1);
      set_want(1, 0, 1'b0, 1'b0, '0, '0);
      set_want(1, 1, 1'b1, 1'b1, 32'h44, 32'h1234);
      step();
      check("t4_m1_wait1", 32'(s_g1[1]), 32'd0);
      step();
      check("t4_m1_wait2", 32'(s_g1[1]), 32'd0);
      step();
      check("t4_m1_gnt", 32'(s_g1[1]), 32'd1);
      check("t4_m0_rvalid", 32'(s_rv0[1]), 32'd1);
      drain();

      // Fixed priority with starvation guard at 4
      set_want(2, 0, 1'b1, 1'b1, 32'h300, 32'h11);
      set_want(2, 1, 1'b1, 1'b1, 32'h304, 32'h22);
      for (int k = 0; k < 20; k++) begin
         step();
         check($sformatf("t5_m1_gnt_k%0d", k), 32'(s_g1[2]), 32'((k % 5) == 4));
      end
      drain();

      // m1 read then m0 write one cycle later at latency 2
      set_want(2, 1, 1'b1, 1'b0, 32'h80, 32'h0);
      step();
      check("t6_m1_gnt", 32'(s_g1[2]), 32'd1);
      set_want(2, 1, 1'b0, 1'b0, '0, '0);
      set_want(2, 0, 1'b1, 1'b1, 32'h84, 32'h5555);
      step();
      check("t6_m0_stalled", 32'(s_g0[2]), 32'd0);
      set_want(2, 0, 1'b0, 1'b0, '0, '0);
      step();
      check("t6_m0_gnt", 32'(s_g0[2]), 32'd1);
      check("t6_m1_rvalid", 32'(s_rv1[2]), 32'd1);
      check("t6_m1_rdata", m1_rdata[2], mem_rdata[2]);
      check("t6_m0_rvalid", 32'(s_rv0[2]), 32'd0);
      drain();

      // Random traffic with a reset in the middle
      rnd_mode = 1'b1;
      repeat (1500) step();
      apply_reset();
      repeat (1500) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
